// File: rtl/display_scan4_if.sv
// Load handshake bundle for display_scan4: a producer offers 16-bit
// display values, the scanner signals when its pending buffer is free.
interface display_scan4_if;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/display_scan4.sv
// 4-digit multiplexed 7-segment scanner with frame-aligned value updates.
// Optional leading-zero blanking: define DISPLAY_SCAN4_LZB_EN.
module display_scan4 #(
    parameter int SCAN_DIV = 1000
) (
    input  logic            clk,
    input  logic            rst,
    display_scan4_if.slave  ld,
    output logic [3:0]      nibble_out,
    output logic [3:0]      digit_en
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp;
    logic [15:0]   pend;
    logic          pend_valid;
    logic          cnt_last;
    logic          boundary;
    logic          accept;
    logic [3:0]    blank;

    assign cnt_last = (cnt == CNT_MAX);
    assign boundary = cnt_last && (idx == 2'd3);
    assign accept   = ld.load_valid && !pend_valid;

    assign ld.load_ready = ~pend_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            disp       <= 16'h0000;
            pend       <= 16'h0000;
            pend_valid <= 1'b0;
        end else begin
            cnt <= cnt_last ? '0 : cnt + CW'(1);
            if (cnt_last) begin
                idx <= idx + 2'd1;
            end
            // Swap only between frames so a frame never mixes two values.
            if (boundary && pend_valid) begin
                disp       <= pend;
                pend_valid <= 1'b0;
            end
            if (accept) begin
                pend       <= ld.load_data;
                pend_valid <= 1'b1;
            end
        end
    end

`ifdef DISPLAY_SCAN4_LZB_EN
    assign blank = {
        disp[15:12] == 4'h0,
        disp[15:8]  == 8'h00,
        disp[15:4]  == 12'h000,
        1'b0
    };
`else
    assign blank = 4'b0000;
`endif

    always_comb begin
        nibble_out = 4'h0;
        unique case (idx)
            2'd0: nibble_out = disp[3:0];
            2'd1: nibble_out = disp[7:4];
            2'd2: nibble_out = disp[11:8];
            2'd3: nibble_out = disp[15:12];
            default: nibble_out = 4'h0;
        endcase
    end

    // First cycle of each slot stays dark to hide segment transitions.
    always_comb begin
        digit_en = 4'b0000;
        if ((cnt != '0) && !blank[idx]) begin
            digit_en = 4'b0001 << idx;
        end
    end

endmodule
